// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: M stage has priority,
// F stage is forced through after STARVE_MAX consecutive M grants.
//
// state  | meaning
// IDLE   | sample requests, pick winner, latch the transaction
// ACCESS | memory busy for MEM_LAT cycles, strobe in the first
// RESP   | one-cycle ack to the winner
module dmem_arbiter #(
  parameter int DEPTH      = 2048,
  parameter int ADDR_W     = 11,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_m_req,
  input  logic              i_m_we,
  input  logic [63:0]       i_m_addr,
  input  logic [63:0]       i_m_wdata,
  output logic              o_m_ack,
  output logic [63:0]       o_m_rdata,
  output logic              o_m_err,
  input  logic              i_f_req,
  input  logic [63:0]       i_f_addr,
  output logic              o_f_ack,
  output logic [63:0]       o_f_rdata,
  output logic              o_f_err,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [63:0]       o_mem_wdata,
  input  logic [63:0]       i_mem_rdata,
  output logic              o_m_stall,
  output logic              o_f_stall
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic [STV_W-1:0]   r_starve_cnt;
  logic               r_id_f;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [63:0]        r_wdata;
  logic [63:0]        r_m_rdata;
  logic [63:0]        r_f_rdata;
  logic               r_m_err;
  logic               r_f_err;

  logic               w_grant;
  logic               w_grant_f;
  logic [63:0]        w_sel_addr;
  logic               w_illegal;
  logic               w_last_access;
  logic               w_starved;

  assign w_starved     = (r_starve_cnt == STV_W'(STARVE_MAX));
  assign w_grant       = i_m_req | i_f_req;
  assign w_grant_f     = i_f_req & (~i_m_req | w_starved);
  assign w_sel_addr    = w_grant_f ? i_f_addr : i_m_addr;
  // full 64-bit compare: high address bits must not alias into the array
  assign w_illegal     = (w_sel_addr >= 64'(DEPTH));
  assign w_last_access = (r_lat_cnt == LAT_W'(MEM_LAT - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_m_ack     = 1'b0;
    o_f_ack     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) w_state_nxt = w_illegal ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        o_mem_en = (r_lat_cnt == '0);
        o_mem_we = (r_lat_cnt == '0) & r_we;
        if (w_last_access) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        o_m_ack     = ~r_id_f;
        o_f_ack     = r_id_f;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_id_f       <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_m_rdata    <= '0;
      r_f_rdata    <= '0;
      r_m_err      <= 1'b0;
      r_f_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!i_f_req || w_grant_f)
            r_starve_cnt <= '0;
          else if (i_m_req && !w_starved)
            r_starve_cnt <= r_starve_cnt + STV_W'(1);
          if (w_grant) begin
            r_id_f    <= w_grant_f;
            r_we      <= ~w_grant_f & i_m_we;
            r_addr    <= w_sel_addr[ADDR_W-1:0];
            r_wdata   <= w_grant_f ? 64'd0 : i_m_wdata;
            r_lat_cnt <= '0;
            if (w_illegal) begin
              if (w_grant_f) begin
                r_f_err   <= 1'b1;
                r_f_rdata <= '0;
              end else begin
                r_m_err   <= 1'b1;
                r_m_rdata <= '0;
              end
            end
          end
        end
        S_ACCESS: begin
          if (w_last_access) begin
            if (r_id_f) begin
              r_f_err   <= 1'b0;
              r_f_rdata <= i_mem_rdata;
            end else begin
              r_m_err   <= 1'b0;
              r_m_rdata <= r_we ? 64'd0 : i_mem_rdata;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt + LAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_m_rdata   = r_m_rdata;
  assign o_m_err     = r_m_err;
  assign o_f_rdata   = r_f_rdata;
  assign o_f_err     = r_f_err;
  assign o_m_stall   = i_m_req & ~o_m_ack;
  assign o_f_stall   = i_f_req & ~o_f_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance A (MEM_LAT=1) and instance B (MEM_LAT=3),
// each with a behavioural memory; random traffic checked against a reference model.
module tb_dmem_arbiter;
  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_m_req, a_m_we, a_f_req;
  logic [63:0] a_m_addr, a_m_wdata, a_f_addr;
  logic        a_m_ack, a_m_err, a_f_ack, a_f_err, a_mem_en, a_mem_we, a_m_stall, a_f_stall;
  logic [63:0] a_m_rdata, a_f_rdata, a_mem_wdata, a_mem_rdata;
  logic [10:0] a_mem_addr;

  logic        b_m_req, b_m_we, b_f_req;
  logic [63:0] b_m_addr, b_m_wdata, b_f_addr;
  logic        b_m_ack, b_m_err, b_f_ack, b_f_err, b_mem_en, b_mem_we, b_m_stall, b_f_stall;
  logic [63:0] b_m_rdata, b_f_rdata, b_mem_wdata, b_mem_rdata;
  logic [10:0] b_mem_addr;

  dmem_arbiter #(.DEPTH(2048), .ADDR_W(11), .MEM_LAT(1), .STARVE_MAX(4)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m_req(a_m_req), .i_m_we(a_m_we), .i_m_addr(a_m_addr), .i_m_wdata(a_m_wdata),
    .o_m_ack(a_m_ack), .o_m_rdata(a_m_rdata), .o_m_err(a_m_err),
    .i_f_req(a_f_req), .i_f_addr(a_f_addr),
    .o_f_ack(a_f_ack), .o_f_rdata(a_f_rdata), .o_f_err(a_f_err),
    .o_mem_en(a_mem_en), .o_mem_we(a_mem_we), .o_mem_addr(a_mem_addr),
    .o_mem_wdata(a_mem_wdata), .i_mem_rdata(a_mem_rdata),
    .o_m_stall(a_m_stall), .o_f_stall(a_f_stall));

  dmem_arbiter #(.DEPTH(2048), .ADDR_W(11), .MEM_LAT(3), .STARVE_MAX(4)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m_req(b_m_req), .i_m_we(b_m_we), .i_m_addr(b_m_addr), .i_m_wdata(b_m_wdata),
    .o_m_ack(b_m_ack), .o_m_rdata(b_m_rdata), .o_m_err(b_m_err),
    .i_f_req(b_f_req), .i_f_addr(b_f_addr),
    .o_f_ack(b_f_ack), .o_f_rdata(b_f_rdata), .o_f_err(b_f_err),
    .o_mem_en(b_mem_en), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr),
    .o_mem_wdata(b_mem_wdata), .i_mem_rdata(b_mem_rdata),
    .o_m_stall(b_m_stall), .o_f_stall(b_f_stall));

  function automatic logic [63:0] pat(input int a);
    return {32'hC0DE_0000 | 32'(a), 32'(a) ^ 32'h5A5A_5A5A};
  endfunction

  // memories: unwritten words read as a fixed address pattern
  logic [63:0] a_arr [0:2047];
  bit          a_valid [0:2047];
  logic [63:0] b_arr [0:2047];
  bit          b_valid [0:2047];
  int          a_en_count = 0;

  always @(posedge clk) begin
    if (a_mem_en && a_mem_we) begin
      a_arr[a_mem_addr]   <= a_mem_wdata;
      a_valid[a_mem_addr] <= 1'b1;
    end
    if (b_mem_en && b_mem_we) begin
      b_arr[b_mem_addr]   <= b_mem_wdata;
      b_valid[b_mem_addr] <= 1'b1;
    end
  end
  assign a_mem_rdata = a_valid[a_mem_addr] ? a_arr[a_mem_addr] : pat(int'(a_mem_addr));
  assign b_mem_rdata = b_valid[b_mem_addr] ? b_arr[b_mem_addr] : pat(int'(b_mem_addr));

  always @(negedge clk) if (a_mem_en) a_en_count <= a_en_count + 1;

  function automatic logic [63:0] b_peek(input int ad);
    return b_valid[ad] ? b_arr[ad] : pat(ad);
  endfunction
  function automatic logic [63:0] a_peek(input int ad);
    return a_valid[ad] ? a_arr[ad] : pat(ad);
  endfunction

  logic [63:0] ref_a [0:2047];

  function automatic logic [63:0] rand_addr();
    int r;
    r = $urandom_range(0, 5);
    if (r == 0) return 64'd2048 + 64'($urandom_range(0, 100));
    if (r == 1) return {$urandom, $urandom} | 64'h1_0000_0000;
    return 64'($urandom_range(0, 31));
  endfunction

  // single transaction on instance A; runs a fixed 10-cycle window
  task automatic run_a(input bit is_f, input bit we, input logic [63:0] addr, input logic [63:0] wd,
                       output int lat, output logic [63:0] rd, output logic er,
                       output int en_k, output int en_cnt, output logic en_we);
    lat = -1; rd = '0; er = 1'b0; en_k = -1; en_cnt = 0; en_we = 1'b0;
    if (is_f) begin
      a_f_req = 1'b1; a_f_addr = addr;
    end else begin
      a_m_req = 1'b1; a_m_we = we; a_m_addr = addr; a_m_wdata = wd;
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (a_mem_en) begin
        en_cnt++;
        if (en_k < 0) begin en_k = k; en_we = a_mem_we; end
      end
      if (lat < 0 && (is_f ? a_f_ack : a_m_ack)) begin
        lat = k;
        rd  = is_f ? a_f_rdata : a_m_rdata;
        er  = is_f ? a_f_err : a_m_err;
        a_f_req = 1'b0; a_m_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({a_m_ack, a_f_ack, a_mem_en, a_mem_we, a_m_err, a_f_err} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000", {a_m_ack, a_f_ack, a_mem_en, a_mem_we, a_m_err, a_f_err}); end
    total++; if ({a_m_rdata, a_f_rdata, a_mem_wdata} !== 192'd0 || a_mem_addr !== 11'd0) begin
      bad++; $display("FAIL reset_data: got m=%h f=%h wd=%h ad=%h want 0", a_m_rdata, a_f_rdata, a_mem_wdata, a_mem_addr); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat, ek, ec; logic [63:0] rd; logic er, ew;
    run_a(1'b0, 1'b1, 64'd5, 64'hDEAD, lat, rd, er, ek, ec, ew);
    ref_a[5] = 64'hDEAD;
    total++; if (lat !== 2) begin bad++; $display("FAIL wr_latency: got %0d want 2", lat); end
    total++; if (ek !== 1 || ew !== 1'b1 || ec !== 1) begin
      bad++; $display("FAIL wr_strobe: got en_k=%0d we=%b cnt=%0d want 1 1 1", ek, ew, ec); end
    total++; if (rd !== 64'd0 || er !== 1'b0) begin
      bad++; $display("FAIL wr_resp: got rdata=%h err=%b want 0 0", rd, er); end
    run_a(1'b0, 1'b0, 64'd5, 64'd0, lat, rd, er, ek, ec, ew);
    total++; if (lat !== 2 || rd !== 64'hDEAD || er !== 1'b0 || ew !== 1'b0) begin
      bad++; $display("FAIL rd_back: got lat=%0d rdata=%h err=%b we=%b want 2 dead 0 0", lat, rd, er, ew); end
    total++; if (a_m_rdata !== 64'hDEAD) begin
      bad++; $display("FAIL rdata_hold: got %h want dead", a_m_rdata); end
  endtask

  task automatic test_illegal();
    int lat, ek, ec; logic [63:0] rd; logic er, ew;
    run_a(1'b0, 1'b0, 64'd2048, 64'd0, lat, rd, er, ek, ec, ew);
    total++; if (lat !== 1 || er !== 1'b1 || rd !== 64'd0 || ec !== 0) begin
      bad++; $display("FAIL illegal_2048: got lat=%0d err=%b rdata=%h en=%0d want 1 1 0 0", lat, er, rd, ec); end
    run_a(1'b1, 1'b0, 64'h8000_0000_0000_0003, 64'd0, lat, rd, er, ek, ec, ew);
    total++; if (lat !== 1 || er !== 1'b1 || rd !== 64'd0 || ec !== 0) begin
      bad++; $display("FAIL illegal_hi: got lat=%0d err=%b rdata=%h en=%0d want 1 1 0 0", lat, er, rd, ec); end
    run_a(1'b0, 1'b0, 64'd2047, 64'd0, lat, rd, er, ek, ec, ew);
    total++; if (lat !== 2 || er !== 1'b0 || rd !== pat(2047) || ec !== 1) begin
      bad++; $display("FAIL edge_2047: got lat=%0d err=%b rdata=%h en=%0d want 2 0 %h 1", lat, er, rd, ec, pat(2047)); end
  endtask

  task automatic test_m_drop();
    int n, fk;
    n = 0; fk = -1;
    a_m_req = 1'b1; a_m_we = 1'b1; a_m_addr = 64'd9; a_m_wdata = 64'h1234_5678_9ABC_DEF0;
    #1;
    total++; if (a_m_stall !== 1'b1) begin bad++; $display("FAIL m_stall: got %b want 1", a_m_stall); end
    @(negedge clk);
    total++; if (a_mem_en !== 1'b1 || a_mem_we !== 1'b1) begin
      bad++; $display("FAIL drop_strobe: got en=%b we=%b want 1 1", a_mem_en, a_mem_we); end
    a_m_req = 1'b0;
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      if (a_m_ack) begin n++; if (fk < 0) fk = k; end
    end
    ref_a[9] = 64'h1234_5678_9ABC_DEF0;
    total++; if (n !== 1 || fk !== 2) begin bad++; $display("FAIL drop_ack: got n=%0d k=%0d want 1 2", n, fk); end
    total++; if (a_peek(9) !== ref_a[9]) begin
      bad++; $display("FAIL drop_commit: got %h want %h", a_peek(9), ref_a[9]); end
  endtask

  task automatic test_starve();
    bit ord[6]; int ks[6]; int n; logic [5:0] exp_ord;
    exp_ord = 6'b010000;
    n = 0;
    a_m_req = 1'b1; a_m_we = 1'b0; a_m_addr = 64'd10; a_f_req = 1'b1; a_f_addr = 64'd11;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (n < 6) begin
        if (a_m_ack) begin
          ord[n] = 1'b0; ks[n] = k; n++;
          if (n == 6) a_m_req = 1'b0;
        end else if (a_f_ack) begin
          ord[n] = 1'b1; ks[n] = k; n++; a_f_req = 1'b0;
        end
      end
    end
    a_m_req = 1'b0; a_f_req = 1'b0;
    total++; if (n !== 6) begin bad++; $display("FAIL starve_count: got %0d want 6", n); end
    for (int i = 0; i < n; i++) begin
      total++; if (ord[i] !== exp_ord[i]) begin
        bad++; $display("FAIL starve_order[%0d]: got %s want %s", i, ord[i] ? "F" : "M", exp_ord[i] ? "F" : "M"); end
    end
    for (int i = 1; i < n; i++) begin
      total++; if (ks[i] - ks[i-1] !== 3) begin
        bad++; $display("FAIL throughput[%0d]: got %0d want 3", i, ks[i] - ks[i-1]); end
    end
  endtask

  task automatic test_random();
    int exp_en, en_start;
    exp_en = 0; en_start = a_en_count;
    for (int it = 0; it < 40; it++) begin
      int mode, prev, t, l, exp_mk, exp_fk, got_mk, got_fk, n_m, n_f;
      bit m_on, f_on, f_first, is_f, mw;
      logic [63:0] ma, md, fa, ad, d, exp_md, exp_fd, got_md, got_fd;
      logic e, exp_me, exp_fe, got_me, got_fe;
      mode = $urandom_range(0, 2);
      m_on = (mode != 1); f_on = (mode != 0);
      mw = 1'($urandom_range(0, 1));
      ma = rand_addr(); md = {$urandom, $urandom}; fa = rand_addr();
      // an idle cycle with f_req low precedes every iteration, so M wins a tie
      f_first = f_on && !m_on;
      prev = -1; exp_mk = -1; exp_fk = -1;
      exp_md = '0; exp_fd = '0; exp_me = 1'b0; exp_fe = 1'b0;
      for (int g = 0; g < 2; g++) begin
        is_f = (g == 0) ? f_first : !f_first;
        if (is_f ? f_on : m_on) begin
          ad = is_f ? fa : ma;
          t = (prev < 0) ? 0 : prev + 1;
          if (ad >= 64'd2048) begin
            l = 1; d = '0; e = 1'b1;
          end else begin
            l = 2; e = 1'b0; exp_en++;
            if (!is_f && mw) begin d = '0; ref_a[ad[10:0]] = md; end
            else d = ref_a[ad[10:0]];
          end
          prev = t + l;
          if (is_f) begin exp_fk = prev; exp_fd = d; exp_fe = e; end
          else      begin exp_mk = prev; exp_md = d; exp_me = e; end
        end
      end
      a_m_req = m_on; a_m_we = mw; a_m_addr = ma; a_m_wdata = md;
      a_f_req = f_on; a_f_addr = fa;
      got_mk = -1; got_fk = -1; n_m = 0; n_f = 0;
      got_md = '0; got_fd = '0; got_me = 1'b0; got_fe = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (a_m_ack) begin
          n_m++; a_m_req = 1'b0;
          if (got_mk < 0) begin got_mk = k; got_md = a_m_rdata; got_me = a_m_err; end
        end
        if (a_f_ack) begin
          n_f++; a_f_req = 1'b0;
          if (got_fk < 0) begin got_fk = k; got_fd = a_f_rdata; got_fe = a_f_err; end
        end
      end
      total++; if (n_m !== (m_on ? 1 : 0) || got_mk !== exp_mk || got_md !== exp_md || got_me !== exp_me) begin
        bad++; $display("FAIL rand_m[%0d]: got n=%0d k=%0d d=%h e=%b want n=%0d k=%0d d=%h e=%b",
                        it, n_m, got_mk, got_md, got_me, m_on ? 1 : 0, exp_mk, exp_md, exp_me); end
      total++; if (n_f !== (f_on ? 1 : 0) || got_fk !== exp_fk || got_fd !== exp_fd || got_fe !== exp_fe) begin
        bad++; $display("FAIL rand_f[%0d]: got n=%0d k=%0d d=%h e=%b want n=%0d k=%0d d=%h e=%b",
                        it, n_f, got_fk, got_fd, got_fe, f_on ? 1 : 0, exp_fk, exp_fd, exp_fe); end
    end
    total++; if (a_en_count - en_start !== exp_en) begin
      bad++; $display("FAIL rand_mem_en: got %0d want %0d", a_en_count - en_start, exp_en); end
  endtask

  task automatic test_reset_mid_access();
    int acks;
    acks = 0;
    b_m_req = 1'b1; b_m_we = 1'b1; b_m_addr = 64'd7; b_m_wdata = 64'hCAFE_F00D;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; b_m_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (b_m_ack || b_f_ack) acks++;
    end
    total++; if ({b_m_ack, b_f_ack, b_mem_en, b_mem_we, b_m_err, b_f_err} !== 6'b0 ||
                 {b_m_rdata, b_f_rdata, b_mem_wdata} !== 192'd0 || b_mem_addr !== 11'd0) begin
      bad++; $display("FAIL mid_reset_out: got ack=%b%b en=%b ad=%h wd=%h want all 0",
                      b_m_ack, b_f_ack, b_mem_en, b_mem_addr, b_mem_wdata); end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (b_m_ack || b_f_ack) acks++;
    end
    total++; if (acks !== 0) begin bad++; $display("FAIL mid_reset_ack: got %0d want 0", acks); end
    total++; if (b_peek(7) !== 64'hCAFE_F00D) begin
      bad++; $display("FAIL mid_reset_commit: got %h want cafef00d", b_peek(7)); end
  endtask

  task automatic test_f_lat3();
    int stall_bad;
    stall_bad = 0;
    b_f_req = 1'b1; b_f_addr = 64'd0;
    #1;
    if (b_f_stall !== 1'b1) stall_bad++;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (b_f_stall !== 1'b1 || b_f_ack !== 1'b0) stall_bad++;
    end
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL f_stall_window: got %0d bad cycles want 0", stall_bad); end
    @(negedge clk);
    total++; if (b_f_ack !== 1'b1 || b_f_stall !== 1'b0) begin
      bad++; $display("FAIL f_ack_t4: got ack=%b stall=%b want 1 0", b_f_ack, b_f_stall); end
    total++; if (b_f_rdata !== pat(0) || b_f_err !== 1'b0) begin
      bad++; $display("FAIL f_rdata: got %h err=%b want %h 0", b_f_rdata, b_f_err, pat(0)); end
    b_f_req = 1'b0;
    @(negedge clk);
    total++; if (b_f_ack !== 1'b0) begin bad++; $display("FAIL f_ack_once: got %b want 0", b_f_ack); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ref_a[i] = pat(i);
    a_m_req = 1'b0; a_m_we = 1'b0; a_m_addr = '0; a_m_wdata = '0; a_f_req = 1'b0; a_f_addr = '0;
    b_m_req = 1'b0; b_m_we = 1'b0; b_m_addr = '0; b_m_wdata = '0; b_f_req = 1'b0; b_f_addr = '0;
    test_reset();
    test_write_read();
    test_illegal();
    test_m_drop();
    test_starve();
    test_random();
    test_reset_mid_access();
    test_f_lat3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
